// File: rtl/set_scan_ctrl_pkg.sv
// Shared constants for the SET scan sequencer: coordinate layout, job field
// slices and the controller state encoding.
package set_scan_ctrl_pkg;

  localparam int COORD_SZ   = 8;
  // coordinate word is {x[3:0], y[3:0]}, same layout as a centre field
  localparam int X_COORD_HI = 7;
  localparam int X_COORD_LO = 4;
  localparam int Y_COORD_HI = 3;
  localparam int Y_COORD_LO = 0;

  localparam int CENT_A_HI = 23;
  localparam int CENT_A_LO = 16;
  localparam int CENT_B_HI = 15;
  localparam int CENT_B_LO = 8;
  localparam int CENT_C_HI = 7;
  localparam int CENT_C_LO = 0;
  localparam int RAD_A_HI  = 11;
  localparam int RAD_A_LO  = 8;
  localparam int RAD_B_HI  = 7;
  localparam int RAD_B_LO  = 4;
  localparam int RAD_C_HI  = 3;
  localparam int RAD_C_LO  = 0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ROW_START = 3'd2,
    S_SCAN      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  function automatic logic [3:0] coord_x(input logic [COORD_SZ-1:0] c);
    return c[X_COORD_HI:X_COORD_LO];
  endfunction

  function automatic logic [3:0] coord_y(input logic [COORD_SZ-1:0] c);
    return c[Y_COORD_HI:Y_COORD_LO];
  endfunction

endpackage

// File: rtl/set_scan_ctrl.sv
// Job sequencer: latches the job, walks coord_gen row by row over the grid,
// counts evaluator hits and flags any coordinate that disagrees with its own walk.
module set_scan_ctrl
  import set_scan_ctrl_pkg::*;
#(
  parameter int GRID_DIM = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [23:0]         central_i,
  input  logic [11:0]         radius_i,
  input  logic [1:0]          mode_i,
  output logic                coord_en_o,
  output logic [3:0]          start_row_o,
  input  logic [COORD_SZ-1:0] coord_i,
  input  logic                hit_i,
  output logic [23:0]         central_o,
  output logic [11:0]         radius_o,
  output logic [1:0]          mode_o,
  output logic                busy_o,
  output logic                valid_o,
  output logic [CNT_W-1:0]    candidate_o,
  output logic                err_o
);

  localparam logic [3:0]       LAST    = 4'(GRID_DIM);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(GRID_DIM * GRID_DIM);

  state_t     state, nxt;
  logic [3:0] row, xi;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:      if (en_i) nxt = S_LOAD;
      S_LOAD:      nxt = S_ROW_START;
      S_ROW_START: nxt = S_SCAN;
      S_SCAN:      if (xi == LAST) nxt = (row == LAST) ? S_DONE : S_ROW_START;
      S_DONE:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  assign coord_en_o  = (state == S_ROW_START);
  assign start_row_o = coord_en_o ? row : 4'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      row         <= 4'd0;
      xi          <= 4'd0;
      central_o   <= '0;
      radius_o    <= '0;
      mode_o      <= '0;
      candidate_o <= '0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
    end else begin
      state   <= nxt;
      // registered status derived from the state being entered
      busy_o  <= (nxt == S_LOAD) || (nxt == S_ROW_START) || (nxt == S_SCAN);
      valid_o <= (nxt == S_DONE);
      unique case (state)
        S_IDLE: if (en_i) begin
          // job is captured on the edge into LOAD so the cleared count is
          // already visible during the LOAD cycle
          central_o   <= central_i;
          radius_o    <= radius_i;
          mode_o      <= mode_i;
          candidate_o <= '0;
          err_o       <= 1'b0;
        end
        S_LOAD:      row <= 4'd1;
        S_ROW_START: xi  <= 4'd1;
        S_SCAN: begin
          if (candidate_o != MAX_CNT)
            candidate_o <= candidate_o + CNT_W'(hit_i);
          if (coord_x(coord_i) != xi || coord_y(coord_i) != row)
            err_o <= 1'b1;
          xi <= xi + 4'd1;
          if (xi == LAST && row != LAST)
            row <= row + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Directed bench for set_scan_ctrl with a coord_gen model and a simple
// circle evaluator driving hit_i.
module tb_set_scan_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i;
  logic [23:0] central_i;
  logic [11:0] radius_i;
  logic [1:0]  mode_i;
  logic        coord_en_o;
  logic [3:0]  start_row_o;
  logic [7:0]  coord_i;
  logic        hit_i;
  logic [23:0] central_o;
  logic [11:0] radius_o;
  logic [1:0]  mode_o;
  logic        busy_o, valid_o, err_o;
  logic [7:0]  candidate_o;

  int checks = 0;
  int errors = 0;
  int hit_sel = 0;     // 0: never hit, 1: always hit, 2: circle A
  bit skip_en = 1'b0;  // coord model skips x=5 on row 3
  logic [3:0] bx = 4'd0, by = 4'd0;

  always #5 clk_i = ~clk_i;

  set_scan_ctrl #(.GRID_DIM(8), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .central_i(central_i),
    .radius_i(radius_i), .mode_i(mode_i), .coord_en_o(coord_en_o),
    .start_row_o(start_row_o), .coord_i(coord_i), .hit_i(hit_i),
    .central_o(central_o), .radius_o(radius_o), .mode_o(mode_o),
    .busy_o(busy_o), .valid_o(valid_o), .candidate_o(candidate_o), .err_o(err_o)
  );

  always @(posedge clk_i) begin
    if (coord_en_o) begin
      bx <= 4'd1;
      by <= start_row_o;
    end else if (skip_en && by == 4'd3 && bx == 4'd4) bx <= 4'd6;
    else bx <= bx + 4'd1;
  end
  assign coord_i = {bx, by};

  function automatic logic eval(input int sel, input logic [3:0] x, y,
                                input logic [7:0] c, input logic [3:0] r);
    int dx, dy;
    dx = int'(x) - int'(c[7:4]);
    dy = int'(y) - int'(c[3:0]);
    if (sel == 0) return 1'b0;
    if (sel == 1) return 1'b1;
    return (dx * dx + dy * dy) <= int'(r) * int'(r);
  endfunction
  assign hit_i = eval(hit_sel, bx, by, central_o[23:16], radius_o[11:8]);

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // caller raises en_i in cycle T; returns in the valid cycle (or after the budget)
  task automatic run_job(input int p1, input int p2, input bit toggle,
                         output int busy_n, output int valid_at,
                         output logic [7:0] cand1, output logic err1);
    busy_n = 0; valid_at = -1; cand1 = 8'hxx; err1 = 1'bx;
    for (int i = 1; i <= 100; i++) begin
      step();
      en_i = (i == p1) || (i == p2);
      if (toggle) central_i = 24'($urandom);
      if (i == 1) begin cand1 = candidate_o; err1 = err_o; end
      if (busy_o) busy_n++;
      if (valid_o) begin valid_at = i; break; end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy_o), 0);
    chk({tag, ".valid"}, 32'(valid_o), 0);
    chk({tag, ".coord_en"}, 32'(coord_en_o), 0);
    chk({tag, ".err"}, 32'(err_o), 0);
    chk({tag, ".start_row"}, 32'(start_row_o), 0);
    chk({tag, ".candidate"}, 32'(candidate_o), 0);
    chk({tag, ".central"}, 32'(central_o), 0);
    chk({tag, ".radius"}, 32'(radius_o), 0);
    chk({tag, ".mode"}, 32'(mode_o), 0);
  endtask

  initial begin
    int bn, va;
    logic [7:0] c1;
    logic e1;
    rst_i = 1'b1; en_i = 1'b0;
    central_i = 24'h0; radius_i = 12'h0; mode_i = 2'b00;
    step(); step();
    chk_zero("reset");
    rst_i = 1'b0;
    step();

    // all points hit, mode 3 passed through
    hit_sel = 1;
    central_i = 24'hA1B2C3; radius_i = 12'h7E5; mode_i = 2'b11;
    en_i = 1'b1;
    run_job(-1, -1, 1'b0, bn, va, c1, e1);
    chk("all.valid_at", 32'(va), 74);
    chk("all.busy_cycles", 32'(bn), 73);
    chk("all.candidate", 32'(candidate_o), 64);
    chk("all.err", 32'(err_o), 0);
    chk("all.central", 32'(central_o), 32'h00A1B2C3);
    chk("all.radius", 32'(radius_o), 32'h7E5);
    chk("all.mode", 32'(mode_o), 3);
    step();
    chk("all.idle_busy", 32'(busy_o), 0);
    chk("all.idle_valid", 32'(valid_o), 0);
    chk("all.hold_candidate", 32'(candidate_o), 64);

    // circle A at (4,4) radius 2
    hit_sel = 2;
    central_i = 24'h441234; radius_i = 12'h256; mode_i = 2'b00;
    en_i = 1'b1;
    run_job(-1, -1, 1'b0, bn, va, c1, e1);
    chk("circ.valid_at", 32'(va), 74);
    chk("circ.candidate", 32'(candidate_o), 13);
    chk("circ.err", 32'(err_o), 0);
    step();

    // en pulses at T+10 and in DONE are ignored; back-to-back start at T+75
    hit_sel = 1;
    en_i = 1'b1;
    run_job(10, 74, 1'b0, bn, va, c1, e1);
    chk("pulse.valid_at", 32'(va), 74);
    chk("pulse.candidate", 32'(candidate_o), 64);
    step();
    chk("pulse.t75_busy", 32'(busy_o), 0);
    chk("pulse.t75_valid", 32'(valid_o), 0);
    hit_sel = 0;
    central_i = 24'h334455; radius_i = 12'h123; mode_i = 2'b10;
    en_i = 1'b1;
    run_job(-1, -1, 1'b1, bn, va, c1, e1);
    chk("b2b.t76_candidate", 32'(c1), 0);
    chk("b2b.valid_at", 32'(va), 74);
    chk("nohit.candidate", 32'(candidate_o), 0);
    chk("nohit.central_held", 32'(central_o), 32'h00334455);
    chk("nohit.radius_held", 32'(radius_o), 32'h123);
    chk("nohit.mode_held", 32'(mode_o), 2);
    step();

    // coordinate skip on row 3 sets a sticky error
    hit_sel = 1; skip_en = 1'b1;
    en_i = 1'b1;
    run_job(-1, -1, 1'b0, bn, va, c1, e1);
    chk("skip.valid_at", 32'(va), 74);
    chk("skip.err_done", 32'(err_o), 1);
    step();
    chk("skip.err_idle", 32'(err_o), 1);
    skip_en = 1'b0;
    en_i = 1'b1;
    run_job(-1, -1, 1'b0, bn, va, c1, e1);
    chk("clear.err_load", 32'(e1), 0);
    chk("clear.err_done", 32'(err_o), 0);
    chk("clear.candidate", 32'(candidate_o), 64);
    step();

    // reset during row 4 scan (T+32)
    en_i = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      en_i = 1'b0;
    end
    chk("mid.busy_before", 32'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    chk_zero("midrst");
    step();
    rst_i = 1'b0;
    step();
    chk("midrst.after_busy", 32'(busy_o), 0);
    chk("midrst.after_valid", 32'(valid_o), 0);
    en_i = 1'b1;
    run_job(-1, -1, 1'b0, bn, va, c1, e1);
    chk("fresh.valid_at", 32'(va), 74);
    chk("fresh.candidate", 32'(candidate_o), 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_scan_ctrl.md
# set_scan_ctrl

Top-level sequencer for the SET engine. Accepts a job (circle centres, radii, mode) and latches the configuration for the point evaluator. Walks the coordinate generator across all 64 grid points, row by row, and counts the points the evaluator reports as inside the selected set. It sits between the host handshake (`en_i`/`busy_o`/`valid_o`) and the sibling `coord_gen` and evaluator blocks.

## Interface
- `GRID_DIM`, 8: grid points per row and rows per job; coordinates run 1..`GRID_DIM`.
- `CNT_W`, 8: candidate counter width; must hold `GRID_DIM*GRID_DIM`.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `en_i` in 1: job start; sampled only in IDLE.
- `central_i` in 24: three centres, each a {x[3:0], y[3:0]} pair; centre A is in [23:16].
- `radius_i` in 12: three 4-bit radii; radius A is in [11:8].
- `mode_i` in 2: set-selection mode; passed to the evaluator.
- `coord_en_o` out 1: load pulse to `coord_gen`.
- `start_row_o` out 4: row loaded with `coord_en_o`.
- `coord_i` in `COORD_SZ`: current coordinate from `coord_gen`.
- `hit_i` in 1: evaluator result for `coord_i`; combinational, same cycle.
- `central_o` out 24, `radius_o` out 12, `mode_o` out 2: latched job configuration, stable for the whole job.
- `busy_o` out 1: job in progress.
- `valid_o` out 1: one-cycle pulse; `candidate_o` is final.
- `candidate_o` out `CNT_W`: number of hits.
- `err_o` out 1: sticky coordinate-mismatch flag.

## Operation
- States:
  - IDLE: waits for `en_i`.
  - LOAD: latches `central_i`, `radius_i`, `mode_i`; clears `candidate_o` and `err_o`; sets row=1.
  - ROW_START: `coord_en_o`=1, `start_row_o`=row; x index is set to 1.
  - SCAN: 8 cycles, x index 1..8.
  - DONE: `valid_o`=1.
- IDLE → LOAD on `en_i`=1. LOAD → ROW_START.
- ROW_START → SCAN.
- SCAN, each cycle:
  - `candidate_o` += `hit_i`.
  - If `coord_i[X_COORD]` ≠ the x index, or `coord_i[Y_COORD]` ≠ row, set `err_o` (sticky).
  - After x=8: go to ROW_START with row+1 if row<8, else to DONE.
- DONE → IDLE unconditionally.
- `en_i` is ignored outside IDLE, including in DONE.
- The counter saturates at 64. No wrap is possible with `CNT_W`≥7.
- `candidate_o` and `err_o` hold after DONE until the next LOAD.
- The configuration outputs hold their last job value in IDLE.
- `mode_i`=2'b11 is passed through unchanged; its meaning is defined by the evaluator.

## Timing
- Reset values:
  - State: IDLE.
  - `busy_o`, `valid_o`, `coord_en_o`, `err_o`: 0.
  - `start_row_o`, `candidate_o`, `central_o`, `radius_o`, `mode_o`: 0.
- Job cycle map, with `en_i` sampled high in cycle T:
  - LOAD in T+1.
  - Row r ROW_START in T+2+9(r−1); its SCAN runs T+3+9(r−1)..T+10+9(r−1).
  - Row 8 SCAN ends in T+73.
  - DONE in T+74; IDLE in T+75.
- `busy_o`=1 for T+1..T+73; it is 0 in DONE.
- `valid_o`=1 only in T+74.
- Earliest back-to-back start: `en_i` in T+75.
- All outputs are registered, except `coord_en_o` and `start_row_o`, which decode state.
- `rst_i` mid-job: immediate return to reset values. No `valid_o`; the partial count is discarded.

## Structure
- Shared constants go in `def.v`:
  - `COORD_SZ`, `X_COORD`, `Y_COORD`.
  - State encodings (3-bit).
  - The job field slices for centre A/B/C and radius A/B/C.
- No sub-module. `coord_gen` and the evaluator are siblings instantiated with this block at SET top level.

## Test plan
- Reset during row 4 SCAN, then `rst_i` low → all outputs 0, state IDLE. A fresh `en_i` runs a full job: `valid_o` 74 cycles after `en_i`.
- Evaluator model with `hit_i`=1 on every point → `candidate_o`=64; `valid_o` in T+74; `busy_o` high for exactly 73 cycles.
- Centre A=(4,4), radius A=2, mode 0 with the reference evaluator → `candidate_o`=13, `err_o`=0.
- `en_i` pulsed at T+10 and in the DONE cycle (T+74) → both ignored. A second `en_i` at T+75 starts a new job with `candidate_o` cleared in T+76.
- Coordinate model that skips x=5 on row 3 → `err_o`=1 from that cycle, held through DONE. It is cleared by the next LOAD.
- `hit_i`=0 throughout → `candidate_o`=0. `central_o`, `radius_o`, `mode_o` are unchanged while `central_i` toggles mid-job.
